// File: rtl/klotski_pkg.sv
// Shared types for the Klotski move sequencer: grid geometry, the queued move record and FSM states.
package klotski_pkg;

    localparam int GRID_W = 4;
    localparam int GRID_H = 5;
    localparam int X_W    = 2;
    localparam int Y_W    = 3;
    localparam int STEP_W = 15;

    typedef enum logic [3:0] {
        S_IDLE,
        S_TRAVEL,
        S_TRAVEL_WAIT,
        S_GRAB,
        S_MOVE_X,
        S_MOVE_X_WAIT,
        S_MOVE_Y,
        S_MOVE_Y_WAIT,
        S_RELEASE
    } state_t;

    typedef struct packed {
        logic [X_W-1:0] from_x;
        logic [Y_W-1:0] from_y;
        logic [X_W-1:0] to_x;
        logic [Y_W-1:0] to_y;
    } move_t;

    function automatic logic [2:0] abs_diff(input logic [2:0] a, input logic [2:0] b);
        return (a > b) ? (a - b) : (b - a);
    endfunction

endpackage

// File: rtl/move_fifo.sv
// Small move queue; a push while full is dropped, so the producer must honour !full.
module move_fifo
    import klotski_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic  i_Clk,
    input  logic  i_rst_n,
    input  logic  push,
    input  move_t din,
    input  logic  pop,
    output move_t dout,
    output logic  full,
    output logic  empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    move_t         mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge i_Clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset; the pointers define what is valid.
    always_ff @(posedge i_Clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/klotski_move_sequencer.sv
// Turns queued Klotski moves into travel / grab / X leg / Y leg / release commands for the step block.
//  state         | meaning
//  S_IDLE        | waiting for a queued move
//  S_TRAVEL      | head to source cell, magnet off
//  S_TRAVEL_WAIT | waiting for travel done
//  S_GRAB        | magnet on, settling
//  S_MOVE_X(_WAIT)| X leg with piece
//  S_MOVE_Y(_WAIT)| Y leg with piece
//  S_RELEASE     | magnet off, settling
module klotski_move_sequencer
    import klotski_pkg::*;
#(
    parameter int STEPS_PER_CELL = 400,
    parameter int SETTLE_CYCLES  = 5000000,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic              i_Clk,
    input  logic              i_rst_n,
    input  logic              i_move_valid,
    output logic              o_move_ready,
    input  logic [X_W-1:0]    i_from_x,
    input  logic [Y_W-1:0]    i_from_y,
    input  logic [X_W-1:0]    i_to_x,
    input  logic [Y_W-1:0]    i_to_y,
    output logic              o_en,
    output logic [STEP_W-1:0] o_total_steps_x,
    output logic [STEP_W-1:0] o_total_steps_y,
    output logic              o_dir_x,
    output logic              o_dir_y,
    input  logic              i_done,
    output logic              o_magnet,
    output logic [X_W-1:0]    o_head_x,
    output logic [Y_W-1:0]    o_head_y,
    output logic              o_busy,
    output logic              o_err
);

    localparam int                CNT_W       = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0]  SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [STEP_W-1:0] SPC         = STEP_W'(STEPS_PER_CELL);

    if ((GRID_H - 1) * STEPS_PER_CELL > (2**STEP_W) - 1) begin : g_bad_steps
        $error("STEPS_PER_CELL too large for a 15-bit step count");
    end
    if (SETTLE_CYCLES < 1) begin : g_bad_settle
        $error("SETTLE_CYCLES must be at least 1");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("FIFO_DEPTH must be a power of two >= 2");
    end

    state_t           state;
    move_t            mv;
    move_t            in_mv;
    move_t            fifo_dout;
    logic [CNT_W-1:0] settle_cnt;
    logic             ready_en;
    logic             fifo_full;
    logic             fifo_empty;
    logic             coords_ok;
    logic             push;
    logic             pop;
    logic [2:0]       dx_trav;
    logic [2:0]       dy_trav;
    logic [2:0]       dx_leg;
    logic [2:0]       dy_leg;

    function automatic logic [STEP_W-1:0] leg_steps(input logic [2:0] d);
        return STEP_W'(d) * SPC;
    endfunction

    assign in_mv     = '{from_x: i_from_x, from_y: i_from_y, to_x: i_to_x, to_y: i_to_y};
    assign coords_ok = (int'(i_from_x) < GRID_W) && (int'(i_to_x) < GRID_W) &&
                       (int'(i_from_y) < GRID_H) && (int'(i_to_y) < GRID_H);
    // ready stays low for the first cycle after reset release
    assign o_move_ready = ready_en && !fifo_full;
    assign push         = i_move_valid && o_move_ready && coords_ok;
    assign pop          = (state == S_IDLE) && !fifo_empty;
    assign o_busy       = (state != S_IDLE) || !fifo_empty;

    assign dx_trav = abs_diff({1'b0, mv.from_x}, {1'b0, o_head_x});
    assign dy_trav = abs_diff(mv.from_y, o_head_y);
    assign dx_leg  = abs_diff({1'b0, mv.to_x}, {1'b0, o_head_x});
    assign dy_leg  = abs_diff(mv.to_y, o_head_y);

    move_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .i_Clk   (i_Clk),
        .i_rst_n (i_rst_n),
        .push    (push),
        .din     (in_mv),
        .pop     (pop),
        .dout    (fifo_dout),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_ff @(posedge i_Clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state           <= S_IDLE;
            mv              <= '0;
            settle_cnt      <= '0;
            ready_en        <= 1'b0;
            o_en            <= 1'b0;
            o_total_steps_x <= '0;
            o_total_steps_y <= '0;
            o_dir_x         <= 1'b0;
            o_dir_y         <= 1'b0;
            o_magnet        <= 1'b0;
            o_head_x        <= '0;
            o_head_y        <= '0;
            o_err           <= 1'b0;
        end else begin
            ready_en <= 1'b1;
            o_en     <= 1'b0;
            o_err    <= i_move_valid && o_move_ready && !coords_ok;
            case (state)
                S_IDLE: begin
                    if (pop) begin
                        mv    <= fifo_dout;
                        state <= S_TRAVEL;
                    end
                end
                S_TRAVEL: begin
                    if (mv.from_x == o_head_x && mv.from_y == o_head_y) begin
                        o_magnet   <= 1'b1;
                        settle_cnt <= SETTLE_LOAD;
                        state      <= S_GRAB;
                    end else begin
                        o_total_steps_x <= leg_steps(dx_trav);
                        o_total_steps_y <= leg_steps(dy_trav);
                        o_dir_x         <= (mv.from_x > o_head_x);
                        o_dir_y         <= (mv.from_y > o_head_y);
                        o_en            <= 1'b1;
                        state           <= S_TRAVEL_WAIT;
                    end
                end
                S_TRAVEL_WAIT: begin
                    if (i_done) begin
                        o_head_x   <= mv.from_x;
                        o_head_y   <= mv.from_y;
                        o_magnet   <= 1'b1;
                        settle_cnt <= SETTLE_LOAD;
                        state      <= S_GRAB;
                    end
                end
                S_GRAB: begin
                    if (settle_cnt == '0) state <= S_MOVE_X;
                    else                  settle_cnt <= settle_cnt - 1'b1;
                end
                S_MOVE_X: begin
                    if (mv.to_x == o_head_x) begin
                        state <= S_MOVE_Y;
                    end else begin
                        o_total_steps_x <= leg_steps(dx_leg);
                        o_total_steps_y <= '0;
                        o_dir_x         <= (mv.to_x > o_head_x);
                        o_dir_y         <= 1'b0;
                        o_en            <= 1'b1;
                        state           <= S_MOVE_X_WAIT;
                    end
                end
                S_MOVE_X_WAIT: begin
                    if (i_done) begin
                        o_head_x <= mv.to_x;
                        state    <= S_MOVE_Y;
                    end
                end
                S_MOVE_Y: begin
                    if (mv.to_y == o_head_y) begin
                        o_magnet   <= 1'b0;
                        settle_cnt <= SETTLE_LOAD;
                        state      <= S_RELEASE;
                    end else begin
                        o_total_steps_x <= '0;
                        o_total_steps_y <= leg_steps(dy_leg);
                        o_dir_x         <= 1'b0;
                        o_dir_y         <= (mv.to_y > o_head_y);
                        o_en            <= 1'b1;
                        state           <= S_MOVE_Y_WAIT;
                    end
                end
                S_MOVE_Y_WAIT: begin
                    if (i_done) begin
                        o_head_y   <= mv.to_y;
                        o_magnet   <= 1'b0;
                        settle_cnt <= SETTLE_LOAD;
                        state      <= S_RELEASE;
                    end
                end
                S_RELEASE: begin
                    if (settle_cnt == '0) state <= S_IDLE;
                    else                  settle_cnt <= settle_cnt - 1'b1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
